if_id1_hazard_ctrl: RTL and testbench

//  Dual-issue front-end hazard sequencer that drives the stall/flush controls of the IF->ID1 pair register.

---
 rtl/if_id1_hazard_ctrl_if.sv | 41 ++++
 rtl/if_id1_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_if_id1_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_id1_hazard_ctrl_if.sv
// Hazard event / pipeline control bundle between the hazard detectors, the
// hazard sequencer and the IF->ID1 pair register. Perf ports exist only with IF_ID1_PERF_CNT_EN.
interface if_id1_hazard_ctrl_if
`ifdef IF_ID1_PERF_CNT_EN
  #(parameter int CNT_W = 16)
`endif
  ;
  logic mispredict_E;
  logic jump_D_1;
  logic jump_D_2;
  logic load_use_D;
  logic pair_conflict_D;
  logic stall_outer;
  logic flush_F_1;
  logic flush_F_2;
  logic kill_D_2;
  logic split_D;
  logic issue2_only_D;
  logic busy;
`ifdef IF_ID1_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall;
  logic [CNT_W-1:0] perf_flush;
  logic [CNT_W-1:0] perf_split;
`endif

  modport slave (
    input  mispredict_E, jump_D_1, jump_D_2, load_use_D, pair_conflict_D,
    output stall_outer, flush_F_1, flush_F_2, kill_D_2, split_D, issue2_only_D, busy
`ifdef IF_ID1_PERF_CNT_EN
    , output perf_stall, perf_flush, perf_split
`endif
  );

  modport master (
    output mispredict_E, jump_D_1, jump_D_2, load_use_D, pair_conflict_D,
    input  stall_outer, flush_F_1, flush_F_2, kill_D_2, split_D, issue2_only_D, busy
`ifdef IF_ID1_PERF_CNT_EN
    , input perf_stall, perf_flush, perf_split
`endif
  );
endinterface

// File: rtl/if_id1_hazard_ctrl.sv
// Dual-issue IF->ID1 hazard sequencer: arbitrates redirect/jump/load-use/pair-split events
// into stall and per-slot flush controls. IF_ID1_PERF_CNT_EN adds saturating perf counters.
module if_id1_hazard_ctrl #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int LOAD_USE_STALL   = 1
`ifdef IF_ID1_PERF_CNT_EN
  , parameter int CNT_W          = 16
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  if_id1_hazard_ctrl_if.slave        hz
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_REDIR   = 2'd1,
    ST_LDSTALL = 2'd2,
    ST_SPLIT   = 2'd3
  } state_t;

  localparam logic [2:0] REDIR_LOAD = 3'(REDIRECT_BUBBLES);
  localparam logic [2:0] LU_LOAD    = 3'(LOAD_USE_STALL - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;
  logic [2:0] cnt_dec_s;
  logic       stall_s;
  logic       flush_s;
  logic       kill_s;
  logic       split_s;
  logic       iss2_s;

  // Counter never wraps below zero.
  assign cnt_dec_s = (cnt_r != 3'd0) ? (cnt_r - 3'd1) : 3'd0;

  // Event arbitration and next-state selection; a mispredict wins from every state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    flush_s     = 1'b0;
    kill_s      = 1'b0;
    split_s     = 1'b0;
    iss2_s      = 1'b0;
    if (hz.mispredict_E) begin
      flush_s = 1'b1;
      if (REDIR_LOAD != 3'd0) begin
        state_nxt_s = ST_REDIR;
        cnt_nxt_s   = REDIR_LOAD;
      end else begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = 3'd0;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hz.jump_D_1) begin
            flush_s = 1'b1;
            kill_s  = 1'b1;
          end else if (hz.jump_D_2) begin
            flush_s = 1'b1;
          end else if (hz.load_use_D) begin
            stall_s = 1'b1;
            if (LU_LOAD != 3'd0) begin
              state_nxt_s = ST_LDSTALL;
              cnt_nxt_s   = LU_LOAD;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else if (hz.pair_conflict_D) begin
            stall_s     = 1'b1;
            split_s     = 1'b1;
            state_nxt_s = ST_SPLIT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_REDIR: begin
          flush_s   = 1'b1;
          cnt_nxt_s = cnt_dec_s;
          if (cnt_r <= 3'd1) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_REDIR;
          end
        end
        ST_LDSTALL: begin
          stall_s   = 1'b1;
          cnt_nxt_s = cnt_dec_s;
          if (cnt_r <= 3'd1) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_LDSTALL;
          end
        end
        ST_SPLIT: begin
          // Held slot 2 issues alone; only a slot-2 jump can still redirect fetch.
          iss2_s      = 1'b1;
          state_nxt_s = ST_RUN;
          if (hz.jump_D_2) begin
            flush_s = 1'b1;
          end else begin
            flush_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 3'd0;
        end
      endcase
    end
  end

  // State and recovery counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Outputs are forced low while reset is held so no stall or flush leaks out.
  assign hz.stall_outer   = reset & stall_s;
  assign hz.flush_F_1     = reset & flush_s;
  assign hz.flush_F_2     = reset & flush_s;
  assign hz.kill_D_2      = reset & kill_s;
  assign hz.split_D       = reset & split_s;
  assign hz.issue2_only_D = reset & iss2_s;
  assign hz.busy          = reset & (state_r != ST_RUN);

`ifdef IF_ID1_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_r;
  logic [CNT_W-1:0] perf_flush_r;
  logic [CNT_W-1:0] perf_split_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_r <= {CNT_W{1'b0}};
      perf_flush_r <= {CNT_W{1'b0}};
      perf_split_r <= {CNT_W{1'b0}};
    end else begin
      perf_stall_r <= sat_inc(perf_stall_r, stall_s);
      perf_flush_r <= sat_inc(perf_flush_r, flush_s);
      perf_split_r <= sat_inc(perf_split_r, split_s);
    end
  end

  assign hz.perf_stall = perf_stall_r;
  assign hz.perf_flush = perf_flush_r;
  assign hz.perf_split = perf_split_r;
`endif

endmodule

// File: tb/tb_if_id1_hazard_ctrl.sv
// Scoreboard bench for if_id1_hazard_ctrl: directed recovery sequences plus random events,
// checked against a cycle-budget reference model (REDIRECT_BUBBLES=2, LOAD_USE_STALL=3).
module tb_if_id1_hazard_ctrl;
  localparam int RB  = 2;
  localparam int LUS = 3;

  typedef struct {
    logic [6:0] o;   // {stall, flush1, flush2, kill2, split, issue2_only, busy}
    int         cyc;
    int         ps;
    int         pf;
    int         pp;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   cyc;
  exp_t q[$];

  // Reference model: remaining work expressed as cycle budgets.
  int   redir_left;
  int   stall_left;
  bit   split_pend;
  int   cnt_stall;
  int   cnt_flush;
  int   cnt_split;

  if_id1_hazard_ctrl_if hz ();

  if_id1_hazard_ctrl #(
    .REDIRECT_BUBBLES(RB),
    .LOAD_USE_STALL  (LUS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input bit rst_n, input bit mp, input bit j1, input bit j2,
                      input bit lu, input bit pc);
    exp_t e;
    bit   stall, flush, kill, split, iss2, busy;
    @(posedge clk);
    #1;
    reset              = rst_n;
    hz.mispredict_E    = mp;
    hz.jump_D_1        = j1;
    hz.jump_D_2        = j2;
    hz.load_use_D      = lu;
    hz.pair_conflict_D = pc;
    {stall, flush, kill, split, iss2, busy} = 6'b0;
    if (!rst_n) begin
      redir_left = 0;
      stall_left = 0;
      split_pend = 1'b0;
      cnt_stall  = 0;
      cnt_flush  = 0;
      cnt_split  = 0;
    end else begin
      busy = (redir_left > 0) || (stall_left > 0) || split_pend;
      if (mp) begin
        flush      = 1'b1;
        redir_left = RB;
        stall_left = 0;
        split_pend = 1'b0;
      end else if (redir_left > 0) begin
        flush      = 1'b1;
        redir_left = redir_left - 1;
      end else if (stall_left > 0) begin
        stall      = 1'b1;
        stall_left = stall_left - 1;
      end else if (split_pend) begin
        iss2       = 1'b1;
        flush      = j2;
        split_pend = 1'b0;
      end else if (j1) begin
        flush = 1'b1;
        kill  = 1'b1;
      end else if (j2) begin
        flush = 1'b1;
      end else if (lu) begin
        stall      = 1'b1;
        stall_left = LUS - 1;
      end else if (pc) begin
        stall      = 1'b1;
        split      = 1'b1;
        split_pend = 1'b1;
      end
    end
    e.o   = {stall, flush, flush, kill, split, iss2, busy};
    e.cyc = cyc;
    e.ps  = cnt_stall;
    e.pf  = cnt_flush;
    e.pp  = cnt_split;
    q.push_back(e);
    cnt_stall = cnt_stall + int'(stall);
    cnt_flush = cnt_flush + int'(flush);
    cnt_split = cnt_split + int'(split);
    cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare the DUT's outputs each cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t       x;
    logic [6:0] got;
    if (q.size() > 0) begin
      x   = q.pop_front();
      got = {hz.stall_outer, hz.flush_F_1, hz.flush_F_2, hz.kill_D_2,
             hz.split_D, hz.issue2_only_D, hz.busy};
      checks = checks + 1;
      if (got !== x.o) begin
        errors = errors + 1;
        $display("FAIL ctrl cyc=%0d got=%b exp=%b (stall,f1,f2,kill,split,iss2,busy)",
                 x.cyc, got, x.o);
      end
      checks = checks + 1;
      if (hz.stall_outer === 1'b1 && (hz.flush_F_1 === 1'b1 || hz.flush_F_2 === 1'b1)) begin
        errors = errors + 1;
        $display("FAIL stall_vs_flush cyc=%0d got stall=%b flush=%b%b exp no overlap",
                 x.cyc, hz.stall_outer, hz.flush_F_1, hz.flush_F_2);
      end
`ifdef IF_ID1_PERF_CNT_EN
      checks = checks + 1;
      if (int'(hz.perf_stall) != x.ps || int'(hz.perf_flush) != x.pf ||
          int'(hz.perf_split) != x.pp) begin
        errors = errors + 1;
        $display("FAIL perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", x.cyc,
                 hz.perf_stall, hz.perf_flush, hz.perf_split, x.ps, x.pf, x.pp);
      end
`endif
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    redir_left = 0;
    stall_left = 0;
    split_pend = 1'b0;
    cnt_stall  = 0;
    cnt_flush  = 0;
    cnt_split  = 0;
    reset              = 1'b0;
    hz.mispredict_E    = 1'b0;
    hz.jump_D_1        = 1'b0;
    hz.jump_D_2        = 1'b0;
    hz.load_use_D      = 1'b0;
    hz.pair_conflict_D = 1'b0;

    // Reset state, including events asserted while reset is held.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(2);
    // T1: reset in the middle of a load-use stall.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // T2: single mispredict -> three flush cycles.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    // T3: load-use -> three stall cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    // T4: pair conflict -> split then slot-2-only issue.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // T5: mispredict beats load-use; mispredict aborts a stall in progress.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    // T6: slot-1 jump, slot-2 jump, and a slot-2 jump during split.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    // Mispredict re-arming an active redirect, and mispredict during split.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Random event mix with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 149) != 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0));
    end
    idle(2);

    for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
